// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: upstream handshake and serializer signals of the UART transmit
// frame controller. The master side is the byte source plus the serializer; the
// slave side is the frame controller itself.
interface uart_tx_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] P_DATA;
    logic             Data_Valid;
    logic             PAR_EN;
    logic             PAR_TYP;
    logic             ser_data;
    logic             Ser_EN;
    logic [WIDTH-1:0] Ser_Data;
    logic             TX_OUT;
    logic             Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data,
        input  Ser_EN, Ser_Data, TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data,
        output Ser_EN, Ser_Data, TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer. One CLK cycle is one bit period.
// Frame: start bit, WIDTH data bits (LSB first, supplied by the external serializer),
// optional parity bit, STOP_BITS stop bits. Back-to-back frames need no idle gap.
// Build option: define UART_TX_PARITY_EN to build the parity bit path; without it
// PAR_EN/PAR_TYP are ignored and frames never carry a parity bit.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit (0); serializer loads Ser_Data
// DATA   | WIDTH data bits from ser_data; serializer shifts
// PARITY | parity bit (parity builds only)
// STOP   | STOP_BITS stop bits (1); last one may accept the next byte
module uart_tx_ctrl #(
    parameter int WIDTH     = 8,
    parameter int STOP_BITS = 1     // 1 or 2
) (
    input logic           CLK,
    input logic           Reset,
    uart_tx_ctrl_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic             stop_cnt;
    logic [WIDTH-1:0] ser_data_q;
    logic             last_bit;
    logic             last_stop;
    logic             ready;
    logic             accept;
    logic             tx_out;

    assign last_bit  = (bit_cnt == CNT_W'(WIDTH - 1));
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    assign ready     = (state == IDLE) || ((state == STOP) && last_stop);
    assign accept    = ready && bus.Data_Valid;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_bit;

    // Capture parity enable and the parity bit at accept so later input changes cannot touch the frame.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
        end else if (accept) begin
            par_en_q <= bus.PAR_EN;
            par_bit  <= bus.PAR_TYP ? ~^bus.P_DATA : ^bus.P_DATA;
        end
    end
`else
    logic unused_par;
    assign unused_par = bus.PAR_EN ^ bus.PAR_TYP;
`endif

    // Frame sequencer: accept has priority so the last stop cycle can chain straight into START.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            ser_data_q <= '0;
        end else if (accept) begin
            state      <= START;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            ser_data_q <= bus.P_DATA;
        end else begin
            case (state)
                IDLE:  state <= IDLE;
                START: state <= DATA;
                DATA: begin
                    if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                        state <= par_en_q ? PARITY : STOP;
`else
                        state <= STOP;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: state <= STOP;
`endif
                STOP: begin
                    if (last_stop) begin
                        state <= IDLE;
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Serial line mux decoded from the registered state; only DATA passes the serializer bit through.
    always_comb begin
        tx_out = 1'b1;
        case (state)
            START:   tx_out = 1'b0;
            DATA:    tx_out = bus.ser_data;
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_out = par_bit;
`endif
            default: tx_out = 1'b1;
        endcase
    end

    assign bus.TX_OUT   = tx_out;
    assign bus.Busy     = (state != IDLE);
    assign bus.Ser_EN   = (state == START) || (state == DATA);
    assign bus.Ser_Data = ser_data_q;

endmodule
